// File: rtl/axi_full_pkg.sv
// -----------------------------------------------------------------------------
// axi_full_pkg
// Shared AXI4 definitions for the full-protocol register slice:
//   - fixed AXI4 field widths (LEN, SIZE, BURST, CACHE, PROT, QOS, RESP)
//   - burst-type and response encodings
//   - skid buffer state encoding
//   - helper functions that derive per-channel payload widths from the
//     ID/ADDR/DATA/USER parameters of the instantiating module
// -----------------------------------------------------------------------------
package axi_full_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_LOCK_W  = 1;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_QOS_W   = 4;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    // EMPTY: no entry, ONE: output register valid, FULL: output + skid valid
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

    // AW and AR carry the same field set
    function automatic int ax_payload_width(input int id_w, input int addr_w, input int user_w);
        return id_w + addr_w + AXI_LEN_W + AXI_SIZE_W + AXI_BURST_W + AXI_LOCK_W
             + AXI_CACHE_W + AXI_PROT_W + AXI_QOS_W + user_w;
    endfunction

    // WDATA + WSTRB + WLAST + WUSER
    function automatic int w_payload_width(input int data_w, input int user_w);
        return data_w + (data_w / 8) + 1 + user_w;
    endfunction

    // BID + BRESP + BUSER
    function automatic int b_payload_width(input int id_w, input int user_w);
        return id_w + AXI_RESP_W + user_w;
    endfunction

    // RID + RDATA + RRESP + RLAST + RUSER
    function automatic int r_payload_width(input int id_w, input int data_w, input int user_w);
        return id_w + data_w + AXI_RESP_W + 1 + user_w;
    endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// -----------------------------------------------------------------------------
// axi_skid_buffer
// Two-entry valid/ready register slice. in_ready, out_valid and out_data are
// all flop outputs, so no combinational path crosses the slice. One cycle of
// forward latency, full throughput, one beat of skid absorbed on back-pressure.
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and payload
// -----------------------------------------------------------------------------
module axi_skid_buffer
    import axi_full_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_r;
    skid_state_e      next_state_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             load_out_in_s;
    logic             load_out_skid_s;
    logic             load_skid_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Next-state and register-load decode
    always_comb begin
        next_state_s    = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_r)
            SKID_EMPTY: begin
                if (in_fire_s) begin
                    load_out_in_s = 1'b1;
                    next_state_s  = SKID_ONE;
                end else begin
                    next_state_s  = SKID_EMPTY;
                end
            end
            SKID_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    load_out_in_s = 1'b1;
                    next_state_s  = SKID_ONE;
                end else if (in_fire_s) begin
                    load_skid_s   = 1'b1;
                    next_state_s  = SKID_FULL;
                end else if (out_fire_s) begin
                    next_state_s  = SKID_EMPTY;
                end else begin
                    next_state_s  = SKID_ONE;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only the output side can move
                if (out_fire_s) begin
                    load_out_skid_s = 1'b1;
                    next_state_s    = SKID_ONE;
                end else begin
                    next_state_s    = SKID_FULL;
                end
            end
            default: begin
                next_state_s = SKID_EMPTY;
            end
        endcase
    end

    // Control state: in_ready/out_valid registered from the next state so they
    // come straight off flops; in_ready stays low for the whole reset period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= SKID_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s != SKID_FULL);
            out_valid_r <= (next_state_s != SKID_EMPTY);
        end
    end

    // Payload registers: data-only, captured on handshake, no reset
    always_ff @(posedge clk) begin
        if (load_out_in_s) begin
            out_data_r <= in_data;
        end else if (load_out_skid_s) begin
            out_data_r <= skid_data_r;
        end else begin
            out_data_r <= out_data_r;
        end
        if (load_skid_s) begin
            skid_data_r <= in_data;
        end else begin
            skid_data_r <= skid_data_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: rtl/axi_full_reg_slice.sv
// -----------------------------------------------------------------------------
// axi_full_reg_slice
// AXI4 full register slice between an AXI master (S_AXI_* side) and an AXI
// slave (M_AXI_* side). Each of the five channels goes through its own
// axi_skid_buffer; this level only packs and unpacks the channel payloads.
// AW, W, AR flow S -> M; B, R flow M -> S. Channels are fully independent.
// Ports:
//   i_sysclk, i_sysrst     clock, asynchronous active-high reset
//   S_AXI_*                slave port facing the upstream master
//   M_AXI_*                master port facing the downstream slave
// -----------------------------------------------------------------------------
module axi_full_reg_slice
    import axi_full_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_USER_WIDTH = 1
) (
    input  logic                          i_sysclk,
    input  logic                          i_sysrst,
    // S side: write address
    input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [AXI_LEN_W-1:0]          S_AXI_AWLEN,
    input  logic [AXI_SIZE_W-1:0]         S_AXI_AWSIZE,
    input  logic [AXI_BURST_W-1:0]        S_AXI_AWBURST,
    input  logic                          S_AXI_AWLOCK,
    input  logic [AXI_CACHE_W-1:0]        S_AXI_AWCACHE,
    input  logic [AXI_PROT_W-1:0]         S_AXI_AWPROT,
    input  logic [AXI_QOS_W-1:0]          S_AXI_AWQOS,
    input  logic [C_AXI_USER_WIDTH-1:0]   S_AXI_AWUSER,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    // S side: write data
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic [C_AXI_USER_WIDTH-1:0]   S_AXI_WUSER,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    // S side: write response
    output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [AXI_RESP_W-1:0]         S_AXI_BRESP,
    output logic [C_AXI_USER_WIDTH-1:0]   S_AXI_BUSER,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    // S side: read address
    input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [AXI_LEN_W-1:0]          S_AXI_ARLEN,
    input  logic [AXI_SIZE_W-1:0]         S_AXI_ARSIZE,
    input  logic [AXI_BURST_W-1:0]        S_AXI_ARBURST,
    input  logic                          S_AXI_ARLOCK,
    input  logic [AXI_CACHE_W-1:0]        S_AXI_ARCACHE,
    input  logic [AXI_PROT_W-1:0]         S_AXI_ARPROT,
    input  logic [AXI_QOS_W-1:0]          S_AXI_ARQOS,
    input  logic [C_AXI_USER_WIDTH-1:0]   S_AXI_ARUSER,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    // S side: read data
    output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [AXI_RESP_W-1:0]         S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic [C_AXI_USER_WIDTH-1:0]   S_AXI_RUSER,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    // M side: write address
    output logic [C_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [AXI_LEN_W-1:0]          M_AXI_AWLEN,
    output logic [AXI_SIZE_W-1:0]         M_AXI_AWSIZE,
    output logic [AXI_BURST_W-1:0]        M_AXI_AWBURST,
    output logic                          M_AXI_AWLOCK,
    output logic [AXI_CACHE_W-1:0]        M_AXI_AWCACHE,
    output logic [AXI_PROT_W-1:0]         M_AXI_AWPROT,
    output logic [AXI_QOS_W-1:0]          M_AXI_AWQOS,
    output logic [C_AXI_USER_WIDTH-1:0]   M_AXI_AWUSER,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    // M side: write data
    output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic [C_AXI_USER_WIDTH-1:0]   M_AXI_WUSER,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    // M side: write response
    input  logic [C_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [AXI_RESP_W-1:0]         M_AXI_BRESP,
    input  logic [C_AXI_USER_WIDTH-1:0]   M_AXI_BUSER,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    // M side: read address
    output logic [C_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [AXI_LEN_W-1:0]          M_AXI_ARLEN,
    output logic [AXI_SIZE_W-1:0]         M_AXI_ARSIZE,
    output logic [AXI_BURST_W-1:0]        M_AXI_ARBURST,
    output logic                          M_AXI_ARLOCK,
    output logic [AXI_CACHE_W-1:0]        M_AXI_ARCACHE,
    output logic [AXI_PROT_W-1:0]         M_AXI_ARPROT,
    output logic [AXI_QOS_W-1:0]          M_AXI_ARQOS,
    output logic [C_AXI_USER_WIDTH-1:0]   M_AXI_ARUSER,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    // M side: read data
    input  logic [C_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [AXI_RESP_W-1:0]         M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic [C_AXI_USER_WIDTH-1:0]   M_AXI_RUSER,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int AX_W = ax_payload_width(C_AXI_ID_WIDTH, C_AXI_ADDR_WIDTH, C_AXI_USER_WIDTH);
    localparam int W_W  = w_payload_width(C_AXI_DATA_WIDTH, C_AXI_USER_WIDTH);
    localparam int B_W  = b_payload_width(C_AXI_ID_WIDTH, C_AXI_USER_WIDTH);
    localparam int R_W  = r_payload_width(C_AXI_ID_WIDTH, C_AXI_DATA_WIDTH, C_AXI_USER_WIDTH);

    logic [AX_W-1:0] aw_in_s, aw_out_s;
    logic [W_W-1:0]  w_in_s,  w_out_s;
    logic [B_W-1:0]  b_in_s,  b_out_s;
    logic [AX_W-1:0] ar_in_s, ar_out_s;
    logic [R_W-1:0]  r_in_s,  r_out_s;

    // Write address: master -> slave
    assign aw_in_s = {S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                      S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWUSER};
    assign {M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
            M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER} = aw_out_s;

    axi_skid_buffer #(.WIDTH(AX_W)) u_aw (
        .clk(i_sysclk), .rst(i_sysrst),
        .in_valid(S_AXI_AWVALID), .in_ready(S_AXI_AWREADY), .in_data(aw_in_s),
        .out_valid(M_AXI_AWVALID), .out_ready(M_AXI_AWREADY), .out_data(aw_out_s)
    );

    // Write data: master -> slave, not coupled to AW
    assign w_in_s = {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WUSER};
    assign {M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER} = w_out_s;

    axi_skid_buffer #(.WIDTH(W_W)) u_w (
        .clk(i_sysclk), .rst(i_sysrst),
        .in_valid(S_AXI_WVALID), .in_ready(S_AXI_WREADY), .in_data(w_in_s),
        .out_valid(M_AXI_WVALID), .out_ready(M_AXI_WREADY), .out_data(w_out_s)
    );

    // Write response: slave -> master
    assign b_in_s = {M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER};
    assign {S_AXI_BID, S_AXI_BRESP, S_AXI_BUSER} = b_out_s;

    axi_skid_buffer #(.WIDTH(B_W)) u_b (
        .clk(i_sysclk), .rst(i_sysrst),
        .in_valid(M_AXI_BVALID), .in_ready(M_AXI_BREADY), .in_data(b_in_s),
        .out_valid(S_AXI_BVALID), .out_ready(S_AXI_BREADY), .out_data(b_out_s)
    );

    // Read address: master -> slave
    assign ar_in_s = {S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
                      S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER};
    assign {M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
            M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER} = ar_out_s;

    axi_skid_buffer #(.WIDTH(AX_W)) u_ar (
        .clk(i_sysclk), .rst(i_sysrst),
        .in_valid(S_AXI_ARVALID), .in_ready(S_AXI_ARREADY), .in_data(ar_in_s),
        .out_valid(M_AXI_ARVALID), .out_ready(M_AXI_ARREADY), .out_data(ar_out_s)
    );

    // Read data: slave -> master
    assign r_in_s = {M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER};
    assign {S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER} = r_out_s;

    axi_skid_buffer #(.WIDTH(R_W)) u_r (
        .clk(i_sysclk), .rst(i_sysrst),
        .in_valid(M_AXI_RVALID), .in_ready(M_AXI_RREADY), .in_data(r_in_s),
        .out_valid(S_AXI_RVALID), .out_ready(S_AXI_RREADY), .out_data(r_out_s)
    );

endmodule

// File: tb/tb_axi_full_reg_slice.sv
// -----------------------------------------------------------------------------
// tb_axi_full_reg_slice
// Directed bench for axi_full_reg_slice. Inputs change 1 time unit after the
// rising edge and outputs are sampled there too, so each loop iteration sees
// the handshake values that the next edge will act on.
// -----------------------------------------------------------------------------
module tb_axi_full_reg_slice;
    import axi_full_pkg::*;

    logic        clk;
    logic        rst;
    int          n_cmp;
    int          n_err;

    logic [0:0]  S_AXI_AWID, S_AXI_ARID, S_AXI_BID, S_AXI_RID;
    logic [0:0]  M_AXI_AWID, M_AXI_ARID, M_AXI_BID, M_AXI_RID;
    logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR, M_AXI_AWADDR, M_AXI_ARADDR;
    logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN, M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE, M_AXI_AWSIZE, M_AXI_ARSIZE;
    logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, M_AXI_AWBURST, M_AXI_ARBURST;
    logic        S_AXI_AWLOCK, S_AXI_ARLOCK, M_AXI_AWLOCK, M_AXI_ARLOCK;
    logic [3:0]  S_AXI_AWCACHE, S_AXI_ARCACHE, M_AXI_AWCACHE, M_AXI_ARCACHE;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT, M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  S_AXI_AWQOS, S_AXI_ARQOS, M_AXI_AWQOS, M_AXI_ARQOS;
    logic [0:0]  S_AXI_AWUSER, S_AXI_ARUSER, M_AXI_AWUSER, M_AXI_ARUSER;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, M_AXI_AWVALID, M_AXI_AWREADY;
    logic        S_AXI_ARVALID, S_AXI_ARREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0] S_AXI_WDATA, M_AXI_WDATA, S_AXI_RDATA, M_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB, M_AXI_WSTRB;
    logic        S_AXI_WLAST, M_AXI_WLAST, S_AXI_RLAST, M_AXI_RLAST;
    logic [0:0]  S_AXI_WUSER, M_AXI_WUSER, S_AXI_BUSER, M_AXI_BUSER, S_AXI_RUSER, M_AXI_RUSER;
    logic        S_AXI_WVALID, S_AXI_WREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP, M_AXI_BRESP, S_AXI_RRESP, M_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, M_AXI_BVALID, M_AXI_BREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY, M_AXI_RVALID, M_AXI_RREADY;

    axi_full_reg_slice #(
        .C_AXI_ID_WIDTH(1), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32), .C_AXI_USER_WIDTH(1)
    ) dut (
        .i_sysclk(clk), .i_sysrst(rst),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
        .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWQOS(S_AXI_AWQOS),
        .S_AXI_AWUSER(S_AXI_AWUSER), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WUSER(S_AXI_WUSER), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BUSER(S_AXI_BUSER),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(S_AXI_ARLOCK),
        .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARQOS(S_AXI_ARQOS),
        .S_AXI_ARUSER(S_AXI_ARUSER), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RUSER(S_AXI_RUSER), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 16-beat W burst, data 1..16; stall selects the 1,0,0,1 downstream ready pattern
    task automatic w_burst(input bit stall);
        int sent, got, first_c, last_c, drop_c;
        sent = 0; got = 0; first_c = 999; last_c = 999; drop_c = 999;
        S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'd1; S_AXI_WLAST = 1'b0;
        S_AXI_WSTRB = 4'hF; S_AXI_WUSER = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            M_AXI_WREADY = stall ? ((cyc % 4 == 1) || (cyc % 4 == 2) ? 1'b0 : 1'b1) : 1'b1;
            if (!S_AXI_WREADY && drop_c == 999) drop_c = cyc;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                got++;
                chk("w_beat", {M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER},
                    {32'(got), 4'hF, (got == 16), 1'b0});
                if (first_c == 999) first_c = cyc;
                last_c = cyc;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) sent++;
            tick();
            S_AXI_WVALID = (sent < 16);
            S_AXI_WDATA  = 32'(sent + 1);
            S_AXI_WLAST  = (sent + 1 == 16);
        end
        S_AXI_WVALID = 1'b0;
        chk("w_count", 64'(got), 64'd16);
        chk("w_idle_after", M_AXI_WVALID, 1'b0);
        if (stall) begin
            chk("w_ready_drop_cycle", 64'(drop_c), 64'd2);
        end else begin
            chk("w_no_ready_drop", 64'(drop_c), 64'd999);
            chk("w_first_beat_cycle", 64'(first_c), 64'd1);
            chk("w_burst_span", 64'(last_c - first_c), 64'd15);
        end
        M_AXI_WREADY = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        {S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
         S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWUSER, S_AXI_AWVALID} = '0;
        {S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
         S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER, S_AXI_ARVALID} = '0;
        {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WUSER, S_AXI_WVALID} = '0;
        {S_AXI_BREADY, S_AXI_RREADY, M_AXI_AWREADY, M_AXI_WREADY, M_AXI_ARREADY} = '0;
        {M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID} = '0;
        {M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID} = '0;

        // Reset state
        tick(); tick();
        chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
        chk("rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, M_AXI_BREADY, M_AXI_RREADY}, 5'b0);
        rst = 1'b0;
        #1;
        chk("readys_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, M_AXI_BREADY, M_AXI_RREADY}, 5'b0);
        @(posedge clk); #1;
        chk("readys_after_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, M_AXI_BREADY, M_AXI_RREADY}, 5'b11111);

        // Single AW beat
        S_AXI_AWID = 1'b1; S_AXI_AWADDR = 32'h4000_0000; S_AXI_AWLEN = 8'd15; S_AXI_AWSIZE = 3'd2;
        S_AXI_AWBURST = AXI_BURST_INCR; S_AXI_AWLOCK = 1'b0; S_AXI_AWCACHE = 4'd3;
        S_AXI_AWPROT = 3'd0; S_AXI_AWQOS = 4'd0; S_AXI_AWUSER = 1'b1;
        S_AXI_AWVALID = 1'b1; M_AXI_AWREADY = 1'b1;
        chk("aw_no_comb_path", M_AXI_AWVALID, 1'b0);
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("aw_valid_out", M_AXI_AWVALID, 1'b1);
        chk("aw_fields", {M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
                          M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER},
            {1'b1, 32'h4000_0000, 8'd15, 3'd2, 2'b01, 1'b0, 4'd3, 3'd0, 4'd0, 1'b1});
        chk("aw_ready_held", S_AXI_AWREADY, 1'b1);
        tick();
        chk("aw_drained", M_AXI_AWVALID, 1'b0);

        // W bursts: continuous, then with stalls
        w_burst(1'b0);
        w_burst(1'b1);

        // R burst with master stalled for the first 5 cycles
        begin
            int acc, got;
            acc = 0; got = 0;
            M_AXI_RVALID = 1'b1; M_AXI_RID = 1'b1; M_AXI_RDATA = 32'd1;
            M_AXI_RRESP = AXI_RESP_OKAY; M_AXI_RLAST = 1'b0; M_AXI_RUSER = 1'b0;
            for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
                S_AXI_RREADY = (cyc >= 5);
                if (cyc == 5) chk("r_skid_accepted", 64'(acc), 64'd2);
                if (S_AXI_RVALID && S_AXI_RREADY) begin
                    got++;
                    chk("r_beat", {S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER},
                        {1'b1, 32'(got), 2'b00, (got == 16), 1'b0});
                end
                if (M_AXI_RVALID && M_AXI_RREADY) acc++;
                tick();
                M_AXI_RVALID = (acc < 16);
                M_AXI_RDATA  = 32'(acc + 1);
                M_AXI_RLAST  = (acc + 1 == 16);
            end
            M_AXI_RVALID = 1'b0; S_AXI_RREADY = 1'b0;
            chk("r_count", 64'(got), 64'd16);
        end

        // Concurrent AW + W + AR + B
        S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'h0000_1000; S_AXI_AWVALID = 1'b1; M_AXI_AWREADY = 1'b1;
        S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1; M_AXI_WREADY = 1'b1;
        S_AXI_ARID = 1'b1; S_AXI_ARADDR = 32'h2000_0040; S_AXI_ARLEN = 8'd3; S_AXI_ARVALID = 1'b1;
        M_AXI_ARREADY = 1'b1;
        M_AXI_BID = 1'b1; M_AXI_BRESP = AXI_RESP_OKAY; M_AXI_BUSER = 1'b1; M_AXI_BVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        tick();
        {S_AXI_AWVALID, S_AXI_WVALID, S_AXI_ARVALID, M_AXI_BVALID} = 4'b0;
        chk("cc_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, S_AXI_BVALID}, 4'b1111);
        chk("cc_aw_addr", {M_AXI_AWID, M_AXI_AWADDR}, {1'b0, 32'h0000_1000});
        chk("cc_w_data", {M_AXI_WDATA, M_AXI_WLAST}, {32'hDEAD_BEEF, 1'b1});
        chk("cc_ar", {M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN}, {1'b1, 32'h2000_0040, 8'd3});
        chk("cc_b", {S_AXI_BID, S_AXI_BRESP, S_AXI_BUSER}, {1'b1, 2'b00, 1'b1});
        tick();
        chk("cc_drained", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, S_AXI_BVALID}, 4'b0);

        // Reset asserted while beat 8 of a burst is on the output
        M_AXI_WREADY = 1'b1; S_AXI_WLAST = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'(k);
            tick();
        end
        chk("mid_beat8", {M_AXI_WVALID, M_AXI_WDATA}, {1'b1, 32'd8});
        S_AXI_WDATA = 32'd9;
        rst = 1'b1;
        #1;
        chk("mid_rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
        chk("mid_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, M_AXI_BREADY, M_AXI_RREADY}, 5'b0);
        S_AXI_WVALID = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("mid_ready_still_low", S_AXI_WREADY, 1'b0);
        tick();
        chk("mid_ready_back", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, M_AXI_BREADY, M_AXI_RREADY}, 5'b11111);
        chk("mid_no_stale_0", M_AXI_WVALID, 1'b0);
        tick();
        chk("mid_no_stale_1", M_AXI_WVALID, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
